// File: rtl/rx_fsm_param.sv
// -----------------------------------------------------------------------------
// rx_fsm_param
// Serial receive FSM for the RX side of the full-duplex link. It generates the
// receive serial clock sck_rx and shifts in DATA_W data bits from data_rx. An
// optional even-parity bit can follow the data. The remote transmitter changes
// data_rx on each rising edge of sck_rx, so the bit is sampled on the falling
// edge, which is the middle of the bit.
//
// Ports
//   clk           system clock; all logic runs on the rising edge
//   rst           synchronous, active-high reset
//   state_in[1:0] command from the link controller: 01 start, 10 abort, else no-op
//   data_rx       serial data from the remote transmitter
//   sck_rx        generated receive clock (registered, idle low)
//   receive_data  last completed word; held until the next word completes
//   latch_flag    1-cycle pulse after each internal byte boundary
//   finish        1-cycle pulse when a word completes (not for aborted words)
//   finish_fsm    level; set by the first finish, cleared by the next accepted start
//   busy          high while in SHIFT or PAR
//   parity_err    parity result; valid together with finish
// -----------------------------------------------------------------------------
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | waiting for a start command; sck_rx held low
//  ST_SHIFT | generating sck_rx and sampling DATA_W data bits
//  ST_PAR   | one more bit period to sample the parity bit (PARITY_EN only)
//  ST_DONE  | one cycle: publish the word, the finish pulse and parity_err
// -----------------------------------------------------------------------------
module rx_fsm_param #(
    parameter int DATA_W    = 32,
    parameter int SCK_DIV   = 1,
    parameter int MSB_FIRST = 0,
    parameter int PARITY_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        state_in,
    input  logic              data_rx,
    output logic              sck_rx,
    output logic [DATA_W-1:0] receive_data,
    output logic              latch_flag,
    output logic              finish,
    output logic              finish_fsm,
    output logic              busy,
    output logic              parity_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

    localparam logic [1:0] ST_AFTER_DATA = (PARITY_EN != 0) ? ST_PAR : ST_DONE;

    logic [1:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;

    logic              cmd_start;
    logic              cmd_abort;
    logic              running;
    logic              div_tc;
    logic              sample;
    logic [BIT_W-1:0]  bit_next;
    logic [DATA_W-1:0] shreg_next;
    logic              byte_edge;

    assign cmd_start = (state_in == 2'b01);
    assign cmd_abort = (state_in == 2'b10);
    assign running   = (state == ST_SHIFT) || (state == ST_PAR);
    assign div_tc    = (div_cnt == DIV_LAST);

    // sck_rx is about to fall: the transmitter changed data half a bit ago,
    // so data_rx is stable here.
    assign sample    = running && div_tc && sck_rx;
    assign bit_next  = bit_cnt + 1'b1;

    // Byte boundary inside the word. The final boundary is signalled by
    // finish, so latch_flag skips it.
    assign byte_edge = (bit_next[2:0] == 3'd0) && (bit_next < BIT_LAST);

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shreg_next = {shreg[DATA_W-2:0], data_rx};
        end else begin : g_lsb_first
            assign shreg_next = {data_rx, shreg[DATA_W-1:1]};
        end
    endgenerate

    assign busy = running;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            sck_rx       <= 1'b0;
            receive_data <= '0;
            latch_flag   <= 1'b0;
            finish       <= 1'b0;
            finish_fsm   <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            latch_flag <= 1'b0;
            finish     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    sck_rx <= 1'b0;
                    if (cmd_start) begin
                        state      <= ST_SHIFT;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        finish_fsm <= 1'b0;
                    end
                end

                ST_SHIFT, ST_PAR: begin
                    if (cmd_abort) begin
                        // Drop the partial word; published outputs stay as they are.
                        state   <= ST_IDLE;
                        sck_rx  <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        if (div_tc) begin
                            div_cnt <= '0;
                            sck_rx  <= ~sck_rx;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end

                        if (sample) begin
                            if (state == ST_SHIFT) begin
                                shreg      <= shreg_next;
                                bit_cnt    <= bit_next;
                                latch_flag <= byte_edge;
                                if (bit_next == BIT_LAST) begin
                                    state <= ST_AFTER_DATA;
                                end
                            end else begin
                                par_bit <= data_rx;
                                state   <= ST_DONE;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    // The whole word is published at once, together with finish.
                    sck_rx       <= 1'b0;
                    receive_data <= shreg;
                    finish       <= 1'b1;
                    finish_fsm   <= 1'b1;
                    parity_err   <= (PARITY_EN != 0) ? (par_bit ^ (^shreg)) : 1'b0;
                    bit_cnt      <= '0;
                    div_cnt      <= '0;
                    state        <= ST_IDLE;
                end

                default: begin
                    state  <= ST_IDLE;
                    sck_rx <= 1'b0;
                end
            endcase
        end
    end

endmodule
